level_shift_to_pulse: RTL and testbench
=======================================

# level_shift_to_pulse

Receive-side decoder for the detector toggle encoding. In shift mode each detector hit arrives as a level transition on a channel line; this block synchronizes the lines into the fabric clock and regenerates one single-cycle pulse per transition. In pass-through mode it forwards levels unchanged. It also counts events per channel, flags coincidences, and blanks its outputs around reset and mode changes so that line state cannot produce false pulses.

## Interface
Parameters:
- NCH, 2, number of channels.
- CNT_W, 16, per-channel event counter width.
- BLANK, 4, blanking length in clocks after reset or a mode change; legal range is 3 or more.

Ports:
- clkin  in  1  sole clock; all logic is on its rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- encoded  in  NCH  encoded channel lines, asynchronous to clkin.
- decodeAsShift  in  1  mode request, asynchronous: 1 = toggle decode, 0 = level pass-through.
- clr_counts  in  1  synchronous, single-cycle strobe; clears counts and overflow.
- det  out  NCH  decoded output: one pulse per event in shift mode, the level in pass-through mode.
- coinc  out  1  1-cycle pulse when every channel has an event on the same edge.
- decshft  out  1  synchronized mode currently in effect.
- counts  out  NCH*CNT_W  per-channel event counters; channel i occupies bits [i*CNT_W +: CNT_W].
- overflow  out  NCH  sticky per-channel saturation flags.

## Operation
- Input sync: each encoded bit passes through s1 then s2, followed by a history register s3. All three reset to 0.
- Mode sync: on each edge, mode_sr <= {mode_sr[1:0], decodeAsShift} and decshft <= mode_sr[2]. Both reset to 0.
- A mode change is defined as mode_sr[2] != decshft.
- Event definition, per channel:
  - when decshft = 1: ev[i] = s2[i] ^ s3[i];
  - when decshft = 0: ev[i] = s2[i] & ~s3[i], the rising edge of the level.
- FSM has two states, BLANK and RUN. Reset enters BLANK with blank_cnt = 0.
  - BLANK: det = 0, coinc = 0, no counting; s3 <= s2 every cycle; blank_cnt increments. When blank_cnt = BLANK-1, next state is RUN.
  - RUN: s3 <= s2. In shift mode, det <= ev. In pass-through mode, det <= s2. coinc <= &ev. Counters update.
  - A mode change detected in either state forces the next state to BLANK and blank_cnt to 0. det and coinc are 0 on that edge. In BLANK, the count restarts.
- Counters:
  - In RUN, ev[i] = 1 increments counts[i], saturating at 2^CNT_W-1.
  - An event arriving while the counter is already saturated sets overflow[i]. The flag stays set until clr_counts.
  - clr_counts zeroes all counts and overflow flags. It wins over a simultaneous event on the same edge, and that event is not counted; det and coinc still report it.

## Timing
- Reset values: det = 0, coinc = 0, decshft = 0, counts = 0, overflow = 0, all sync and history registers = 0, state = BLANK.
- Asynchronous rstn clears everything immediately; no clock edge is needed.
- Data latency: an encoded transition sampled at edge k appears in s2 after edge k+1. det and the count update follow edge k+2, giving 3 edges of latency. coinc is aligned with det.
- In pass-through mode, det tracks encoded with the same 3-edge delay.
- Mode latency: decshft changes 4 edges after decodeAsShift; BLANK is entered on that same edge. det resumes BLANK+1 edges later.
- Blanking is required. Lines held at 1 through reset, or steady lines across a mode switch, must produce no pulse and no count: s3 tracks s2 throughout BLANK.
- Toggles on consecutive edges in shift mode yield a pulse on each cycle, so det can stay high continuously. Spacing between transitions of at least 2 clocks is needed for sync integrity; this is the sender's responsibility.
- A transition that falls inside BLANK is absorbed and never reported.

## Test plan
1. Hold encoded = 2'b11 and decodeAsShift = 1 through and after reset, then wait 12 cycles. Required: det = 0, counts = 0. Then toggle encoded[0] once. Required: det[0] is high for exactly 1 cycle, 3 edges after sampling; count0 = 1; coinc = 0.
2. Shift mode, toggle both channels on the same edge. Required: det = 2'b11 for 1 cycle, coinc = 1 for 1 cycle, count0 and count1 each +1.
3. decodeAsShift = 0, encoded[1] high for 5 cycles then low. Required: det[1] high for 5 cycles, delayed 3 edges; count1 +1; decshft = 0.
4. CNT_W = 4, 17 toggles on channel 0. Required: count0 = 15 and overflow[0] = 1. Then assert clr_counts on the same edge as one more event. Required: count0 = 0, overflow[0] = 0, and det[0] still pulses.
5. encoded[0] held at 1 in pass-through, then switch to shift mode. Required: decshft goes to 1 after 4 edges; det = 0 for BLANK+1 edges; no count. A subsequent toggle decodes to 1 pulse.
6. Deassert rstn between edges mid-RUN, with det high and counts nonzero. Required: all outputs 0 immediately, the state is BLANK, and there are no pulses during the BLANK cycles that follow rstn release.

Source files
------------

// File: rtl/level_shift_to_pulse.sv
// level_shift_to_pulse
//   Receive-side decoder for the detector toggle encoding. Each encoded line
//   is synchronized into the clkin domain. In shift mode, every level
//   transition becomes a single-cycle pulse on det. In pass-through mode,
//   det follows the synchronized level. Events are counted per channel with
//   saturation and a sticky overflow flag. coinc marks an event on every
//   channel on the same edge. Outputs are blanked for BLANK clocks after
//   reset and after every change of the effective mode.
//
// Ports
//   clkin         sole clock, rising edge
//   rstn          asynchronous active-low reset
//   encoded       encoded channel lines (asynchronous to clkin)
//   decodeAsShift mode request (asynchronous): 1 = toggle decode, 0 = level pass
//   clr_counts    single-cycle strobe: clear counts and overflow flags
//   det           decoded pulses (shift mode) or levels (pass-through mode)
//   coinc         1-cycle pulse when all channels see an event on the same edge
//   decshft       synchronized mode in effect
//   counts        per-channel counters; channel i at [i*CNT_W +: CNT_W]
//   overflow      sticky per-channel saturation flags
`timescale 1ns/1ps
module level_shift_to_pulse #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16,
  parameter int BLANK = 4
) (
  input  logic                 clkin,
  input  logic                 rstn,
  input  logic [NCH-1:0]       encoded,
  input  logic                 decodeAsShift,
  input  logic                 clr_counts,
  output logic [NCH-1:0]       det,
  output logic                 coinc,
  output logic                 decshft,
  output logic [NCH*CNT_W-1:0] counts,
  output logic [NCH-1:0]       overflow
);

  localparam int              BW         = $clog2(BLANK + 1);
  localparam logic [BW-1:0]   BLANK_LAST = BW'(BLANK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {ST_BLANK, ST_RUN} state_t;

  logic [NCH-1:0] s1_reg, s2_reg, s3_reg;
  logic [2:0]     mode_sr_reg;
  logic           decshft_reg;
  state_t         state_reg, state_next;
  logic [BW-1:0]  blank_cnt_reg, blank_cnt_next;
  logic [NCH-1:0] det_reg, det_next;
  logic           coinc_reg, coinc_next;
  logic [NCH-1:0] ev;
  logic           mode_change;
  logic           count_en;

  // Synchronizers and history. s3 follows s2 in every state, so a line
  // that is steady across BLANK cannot create an edge when RUN resumes.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      s3_reg      <= '0;
      mode_sr_reg <= '0;
      decshft_reg <= 1'b0;
    end else begin
      s1_reg      <= encoded;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      mode_sr_reg <= {mode_sr_reg[1:0], decodeAsShift};
      decshft_reg <= mode_sr_reg[2];
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_BLANK;
      blank_cnt_reg <= '0;
      det_reg       <= '0;
      coinc_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      blank_cnt_reg <= blank_cnt_next;
      det_reg       <= det_next;
      coinc_reg     <= coinc_next;
    end
  end

  always_comb begin
    // Toggle decode in shift mode, rising edge of the level otherwise.
    ev             = decshft_reg ? (s2_reg ^ s3_reg) : (s2_reg & ~s3_reg);
    mode_change    = (mode_sr_reg[2] != decshft_reg);
    state_next     = state_reg;
    blank_cnt_next = blank_cnt_reg;
    det_next       = '0;
    coinc_next     = 1'b0;
    count_en       = 1'b0;
    if (mode_change) begin
      // The mode switches on this edge; ev was decoded with the old mode,
      // so nothing is reported and blanking restarts.
      state_next     = ST_BLANK;
      blank_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_BLANK: begin
          if (blank_cnt_reg == BLANK_LAST) begin
            state_next     = ST_RUN;
            blank_cnt_next = '0;
          end else begin
            blank_cnt_next = blank_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          det_next   = decshft_reg ? ev : s2_reg;
          coinc_next = &ev;
          count_en   = 1'b1;
        end
        default: begin
          state_next     = ST_BLANK;
          blank_cnt_next = '0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic             ovf_reg;

      // clr_counts has priority over a same-edge event; that event is lost.
      always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (clr_counts) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (count_en && ev[gi]) begin
          if (cnt_reg == CNT_MAX) ovf_reg <= 1'b1;
          else                    cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign counts[gi*CNT_W +: CNT_W] = cnt_reg;
      assign overflow[gi]              = ovf_reg;
    end
  endgenerate

  assign det     = det_reg;
  assign coinc   = coinc_reg;
  assign decshft = decshft_reg;

endmodule

// File: tb/tb_level_shift_to_pulse.sv
`timescale 1ns/1ps
module tb_level_shift_to_pulse;

  localparam int NCH   = 2;
  localparam int CNT_W = 4;
  localparam int BLANK = 4;
  localparam int MAXE  = 4096;

  logic             clkin = 1'b0;
  logic             rstn;
  logic [NCH-1:0]   encoded;
  logic             decodeAsShift;
  logic             clr_counts;
  logic [NCH-1:0]   det;
  logic             coinc;
  logic             decshft;
  logic [NCH*CNT_W-1:0] counts;
  logic [NCH-1:0]   overflow;

  int tests = 0;
  int fails = 0;

  level_shift_to_pulse #(.NCH(NCH), .CNT_W(CNT_W), .BLANK(BLANK)) dut (
    .clkin(clkin), .rstn(rstn), .encoded(encoded), .decodeAsShift(decodeAsShift),
    .clr_counts(clr_counts), .det(det), .coinc(coinc), .decshft(decshft),
    .counts(counts), .overflow(overflow)
  );

  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: input samples are logged per edge since reset release;
  // outputs are derived from the sample history with the stated latencies.
  logic [NCH-1:0] enc_h [MAXE];
  bit             mode_h [MAXE];
  int             n;
  int             blank_start;
  logic [NCH-1:0] exp_det;
  logic           exp_coinc;
  logic [CNT_W-1:0] exp_cnt [NCH];
  logic           exp_ovf [NCH];
  logic           exp_dec;
  int             det0_hi, det1_hi, coinc_hi;

  function automatic logic [NCH-1:0] enc_at(int k);
    return (k >= 1) ? enc_h[k] : '0;
  endfunction

  // Mode in effect after edge k: the request sampled 3 edges earlier.
  function automatic bit mode_at(int k);
    return (k - 3 >= 1) ? mode_h[k-3] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    n = 0;
    blank_start = 0;
    exp_det = '0;
    exp_coinc = 1'b0;
    exp_dec = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c] = '0;
      exp_ovf[c] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string phase);
    check({phase, ".det"}, 32'(det), 32'(exp_det));
    check({phase, ".coinc"}, 32'(coinc), 32'(exp_coinc));
    check({phase, ".decshft"}, 32'(decshft), 32'(exp_dec));
    check({phase, ".counts"}, 32'(counts), 32'({exp_cnt[1], exp_cnt[0]}));
    check({phase, ".overflow"}, 32'(overflow), 32'({exp_ovf[1], exp_ovf[0]}));
  endtask

  task automatic step(input string phase);
    logic [NCH-1:0] e2, e3, evm;
    bit dm, mc, active;
    @(posedge clkin);
    n++;
    enc_h[n]  = encoded;
    mode_h[n] = decodeAsShift;
    mc = (mode_at(n) != mode_at(n-1));
    if (mc) blank_start = n;
    active = !mc && (n - blank_start >= BLANK + 1);
    e2 = enc_at(n-2);
    e3 = enc_at(n-3);
    dm = mode_at(n-1);
    evm = dm ? (e2 ^ e3) : (e2 & ~e3);
    exp_det   = active ? (dm ? evm : e2) : '0;
    exp_coinc = active && (&evm);
    exp_dec   = mode_at(n);
    for (int c = 0; c < NCH; c++) begin
      if (clr_counts) begin
        exp_cnt[c] = '0;
        exp_ovf[c] = 1'b0;
      end else if (active && evm[c]) begin
        if (exp_cnt[c] == {CNT_W{1'b1}}) exp_ovf[c] = 1'b1;
        else exp_cnt[c] = exp_cnt[c] + 1'b1;
      end
    end
    #1;
    check_outputs(phase);
    det0_hi  += int'(det[0]);
    det1_hi  += int'(det[1]);
    coinc_hi += int'(coinc);
  endtask

  initial begin
    int first;
    rstn = 1'b0;
    encoded = 2'b11;
    decodeAsShift = 1'b1;
    clr_counts = 1'b0;
    reset_model();
    det0_hi = 0; det1_hi = 0; coinc_hi = 0;

    // 1: lines high through reset, then one toggle on channel 0
    repeat (3) @(posedge clkin);
    #1;
    check_outputs("reset");
    @(negedge clkin);
    rstn = 1'b1;
    repeat (12) step("t1_idle");
    check("t1_idle_counts", 32'(counts), 32'd0);
    det0_hi = 0; coinc_hi = 0;
    encoded = 2'b10;
    repeat (6) step("t1_toggle");
    check("t1_det0_pulses", 32'(det0_hi), 32'd1);
    check("t1_coinc_pulses", 32'(coinc_hi), 32'd0);
    check("t1_count0", 32'(counts[3:0]), 32'd1);

    // 2: both channels toggle on the same edge
    det0_hi = 0; det1_hi = 0; coinc_hi = 0;
    encoded = encoded ^ 2'b11;
    repeat (6) step("t2");
    check("t2_coinc_pulses", 32'(coinc_hi), 32'd1);
    check("t2_det1_pulses", 32'(det1_hi), 32'd1);
    check("t2_counts", 32'(counts), 32'h12);

    // 3: pass-through, channel 1 high for 5 cycles
    encoded = 2'b00;
    decodeAsShift = 1'b0;
    repeat (12) step("t3_switch");
    det1_hi = 0;
    encoded = 2'b10;
    repeat (5) step("t3_high");
    encoded = 2'b00;
    repeat (6) step("t3_low");
    check("t3_det1_cycles", 32'(det1_hi), 32'd5);
    check("t3_decshft", 32'(decshft), 32'd0);

    // 4: saturation and overflow on channel 0, then clear against an event
    decodeAsShift = 1'b1;
    repeat (12) step("t4_switch");
    for (int i = 0; i < 17; i++) begin
      encoded[0] = ~encoded[0];
      step("t4_tog");
      step("t4_tog");
    end
    repeat (4) step("t4_settle");
    check("t4_count0_sat", 32'(counts[3:0]), 32'd15);
    check("t4_ovf0", 32'(overflow[0]), 32'd1);
    encoded[0] = ~encoded[0];
    step("t4_clr");
    step("t4_clr");
    clr_counts = 1'b1;
    step("t4_clr_edge");
    clr_counts = 1'b0;
    check("t4_clr_det0", 32'(det[0]), 32'd1);
    check("t4_clr_count0", 32'(counts[3:0]), 32'd0);
    check("t4_clr_ovf0", 32'(overflow[0]), 32'd0);
    repeat (4) step("t4_after");

    // 5: line held high in pass-through, then switch to shift mode
    encoded = 2'b01;
    repeat (6) step("t5_pre");
    decodeAsShift = 1'b0;
    repeat (12) step("t5_pass");
    decodeAsShift = 1'b1;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step("t5_switch");
      if (decshft && first == 0) first = i;
    end
    check("t5_decshft_latency", 32'(first), 32'd4);
    check("t5_count0_steady", 32'(counts[3:0]), 32'd1);
    det0_hi = 0;
    encoded = 2'b00;
    repeat (6) step("t5_toggle");
    check("t5_det0_pulses", 32'(det0_hi), 32'd1);
    check("t5_count0", 32'(counts[3:0]), 32'd2);

    // 6: asynchronous reset mid-RUN while det is high
    encoded = encoded ^ 2'b11;
    repeat (3) step("t6_pre");
    check("t6_det_before", 32'(det), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_det", 32'(det), 32'd0);
    check("t6_rst_coinc", 32'(coinc), 32'd0);
    check("t6_rst_counts", 32'(counts), 32'd0);
    check("t6_rst_overflow", 32'(overflow), 32'd0);
    check("t6_rst_decshft", 32'(decshft), 32'd0);
    reset_model();
    @(posedge clkin);
    @(negedge clkin);
    rstn = 1'b1;
    det0_hi = 0; det1_hi = 0;
    step("t6_blank");
    encoded[0] = ~encoded[0];
    repeat (3) step("t6_blank");
    check("t6_blank_pulses", 32'(det0_hi + det1_hi), 32'd0);
    repeat (12) step("t6_post");

    // Random traffic, clears and mode switches against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) encoded = encoded ^ 2'($urandom_range(1, 3));
      clr_counts = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) decodeAsShift = ~decodeAsShift;
      step("rand");
    end
    clr_counts = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
